// File: rtl/i2s_tdm_tx_pkg.sv
// i2s_tdm_tx_pkg
//   Shared definitions for the I2S/TDM audio serialiser:
//   - state encoding for the serialiser FSM (IDLE, RUN)
//   - frame_bits(): serial bits per frame (channels * slot width)
//   - lvl_w(): width needed to hold a FIFO level of 0..depth
//   - params_ok(): legality of a parameter set, checked at elaboration
//     time by the top level
package i2s_tdm_tx_pkg;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    function automatic int frame_bits(input int channels, input int slot_w);
        return channels * slot_w;
    endfunction

    function automatic int lvl_w(input int fifo_depth);
        return $clog2(fifo_depth + 1);
    endfunction

    function automatic bit params_ok(input int channels, input int sample_w,
                                     input int slot_w, input int clk_div,
                                     input int fifo_depth);
        return (channels >= 2) && (channels <= 8) && ((channels % 2) == 0)
            && (sample_w >= 8) && (sample_w <= 32) && (slot_w >= sample_w)
            && (clk_div >= 2) && ((clk_div % 2) == 0)
            && (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/i2s_tdm_tx_fifo.sv
// sync_fifo
//   Generic single-clock FIFO with synchronous active-high reset and a
//   registered occupancy level. Reset flushes the contents.
//   Ports:
//     clk, reset   system clock, synchronous reset
//     wr_data      word to store, written when push && !full
//     push, pop    requests; ignored when full / empty respectively
//     rd_data      head of queue (valid when !empty)
//     level        words currently stored (0..DEPTH)
//     full, empty  decoded from the registered level
module sync_fifo
    import i2s_tdm_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx
//   N-channel I2S/TDM serialiser with a frame FIFO, prefill start-up and
//   underrun reporting. Everything runs on clk; bck is divided down
//   internally and all output transitions of lrck/sdata happen on the
//   cycle the divider wraps (the bck falling edge).
//   Optional build macro I2S_TDM_TX_LJ_EN selects left-justified data
//   (slot MSB coincident with the slot boundary); undefined gives
//   standard I2S with its one-bit data delay. lrck timing is the same.
//   Ports:
//     clk, reset     system clock, synchronous active-high reset
//     sample_in      one frame, channel 0 in the LSB slice
//     sample_valid   frame offered; accepted when sample_ready is high
//     sample_ready   FIFO not full (from the registered level)
//     bck, lrck      bit clock and frame/word select
//     sdata          serial data, MSB first per slot
//     underrun       one-clk pulse when a frame start finds the FIFO empty
//     fifo_level     frames currently queued
module i2s_tdm_tx
    import i2s_tdm_tx_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 16,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS*SAMPLE_W-1:0]     sample_in,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    output logic                             bck,
    output logic                             lrck,
    output logic                             sdata,
    output logic                             underrun,
    output logic [lvl_w(FIFO_DEPTH)-1:0]     fifo_level
);

    localparam int FB    = frame_bits(CHANNELS, SLOT_W);
    localparam int IN_W  = CHANNELS * SAMPLE_W;
    localparam int LVL_W = lvl_w(FIFO_DEPTH);
    localparam int BIT_W = $clog2(FB);
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FB - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(FB / 2);
    localparam logic [LVL_W-1:0] PREFILL  = LVL_W'(FIFO_DEPTH / 2);

    generate
        if (!params_ok(CHANNELS, SAMPLE_W, SLOT_W, CLK_DIV, FIFO_DEPTH)) begin : g_bad_params
            $error("i2s_tdm_tx: illegal parameter combination");
        end
    endgenerate

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [BIT_W-1:0] bit_idx;
    logic [FB-1:0]    shreg;
    logic [FB-1:0]    frame_vec;
    logic [IN_W-1:0]  fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             fall_tick;
    logic             frame_start;
    logic             stream_bit;
`ifndef I2S_TDM_TX_LJ_EN
    logic             held_bit;
`endif

    assign sample_ready = !fifo_full;
    assign push         = sample_valid && sample_ready;
    assign div_next     = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    assign fall_tick    = (state == RUN) && (div_cnt == DIV_LAST);
    assign frame_start  = fall_tick && (bit_idx == '0);

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_data (sample_in),
        .push    (push),
        .pop     (frame_start),
        .rd_data (fifo_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Lay the FIFO head out in transmit order: slot 0 in the frame MSBs,
    // each sample left-aligned in its slot with zero pad below. An empty
    // FIFO yields an all-zero frame for the underrun case.
    always_comb begin
        frame_vec = '0;
        if (!fifo_empty) begin
            for (int c = 0; c < CHANNELS; c++) begin
                frame_vec[FB-1-c*SLOT_W -: SAMPLE_W] = fifo_data[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // The undelayed serial stream; at a frame start the MSB comes straight
    // from the freshly formatted frame rather than the shift register.
    assign stream_bit = frame_start ? frame_vec[FB-1] : shreg[FB-1];

    // FSM, divider and serialiser. bck is registered from the next divider
    // count so it is high for the upper half of each bit period and falls
    // on the same edge that lrck/sdata change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            bck      <= 1'b0;
            lrck     <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
`ifndef I2S_TDM_TX_LJ_EN
            held_bit <= 1'b0;
`endif
        end else begin
            underrun <= 1'b0;
            if (state == IDLE) begin
                if (fifo_level >= PREFILL) begin
                    state <= RUN;
                end
            end else begin
                div_cnt <= div_next;
                bck     <= (div_next >= DIV_HALF);
                if (fall_tick) begin
                    bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
                    lrck    <= (bit_idx >= BIT_HALF);
                    if (frame_start) begin
                        shreg    <= frame_vec << 1;
                        underrun <= fifo_empty;
                    end else begin
                        shreg <= shreg << 1;
                    end
`ifdef I2S_TDM_TX_LJ_EN
                    sdata <= stream_bit;
`else
                    held_bit <= stream_bit;
                    sdata    <= held_bit;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx
//   Directed bench for i2s_tdm_tx: a default stereo instance and a 4-channel
//   24-in-32 TDM instance. Expected serial data depends on whether
//   I2S_TDM_TX_LJ_EN is defined for the build.
module tb_i2s_tdm_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        sample_ready, bck, lrck, sdata, underrun;
    logic [2:0]  fifo_level;

    logic [95:0] sample_in4;
    logic        sample_valid4;
    logic        sample_ready4, bck4, lrck4, sdata4, underrun4;
    logic [2:0]  fifo_level4;

    int checks = 0;
    int fails  = 0;

    localparam logic [15:0] A0 = 16'hA5C3, A1 = 16'h8001;
    localparam logic [15:0] B0 = 16'h5A5A, B1 = 16'h0003;
    localparam logic [15:0] C0 = 16'h0FF0, C1 = 16'h1111;
`ifdef I2S_TDM_TX_LJ_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    always #5 clk = ~clk;

    i2s_tdm_tx dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bck          (bck),
        .lrck         (lrck),
        .sdata        (sdata),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    i2s_tdm_tx #(
        .CHANNELS (4),
        .SAMPLE_W (24),
        .SLOT_W   (32)
    ) dut4 (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in4),
        .sample_valid (sample_valid4),
        .sample_ready (sample_ready4),
        .bck          (bck4),
        .lrck         (lrck4),
        .sdata        (sdata4),
        .underrun     (underrun4),
        .fifo_level   (fifo_level4)
    );

    // Expected sdata for bit k of a frame whose transmit-order stream is
    // s[fb-1:0]; prev is the last stream bit of the preceding frame.
    function automatic logic exp_bit(input logic [127:0] s, input int fb,
                                     input logic prev, input int k);
        if (LJ) return s[fb-1-k];
        else if (k == 0) return prev;
        else return s[fb-k];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_valid4 = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // Pushes two frames on consecutive clocks and leaves the bench just
    // after the first fall tick (bit 0 of the first frame).
    task automatic prefill(input logic [31:0] f0, input logic [31:0] f1);
        sample_valid = 1'b1;
        sample_in = f0;
        step(1);
        sample_in = f1;
        step(1);
        sample_valid = 1'b0;
        step(5);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_valid4 = 1'b0;
        sample_in = '0;
        sample_in4 = '0;
        step(3);
        checks++; if (bck !== 1'b0) begin fails++; $display("[TB] FAIL reset_bck: got %b want 0", bck); end
        checks++; if (lrck !== 1'b0) begin fails++; $display("[TB] FAIL reset_lrck: got %b want 0", lrck); end
        checks++; if (sdata !== 1'b0) begin fails++; $display("[TB] FAIL reset_sdata: got %b want 0", sdata); end
        checks++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_underrun: got %b want 0", underrun); end
        checks++; if (fifo_level !== 3'd0) begin fails++; $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (sample_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b want 1", sample_ready); end
        reset = 1'b0;
        sample_valid = 1'b1;
        sample_in = {A1, A0};
        step(1);
        sample_valid = 1'b0;
        step(20);
        checks++; if (fifo_level !== 3'd1) begin fails++; $display("[TB] FAIL below_prefill_level: got %0d want 1", fifo_level); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bck !== 1'b0) begin fails++; $display("[TB] FAIL below_prefill_bck: got %b want 0", bck); end
            step(1);
        end
    endtask

    task automatic test_frame();
        logic [127:0] sa, sb;
        logic e, el;
        sa = 128'({A0, A1});
        sb = 128'({B0, B1});
        apply_reset();
        prefill({A1, A0}, {B1, B0});
        checks++; if (fifo_level !== 3'd1) begin fails++; $display("[TB] FAIL frame1_level: got %0d want 1", fifo_level); end
        for (int k = 0; k < 32; k++) begin
            e = exp_bit(sa, 32, 1'b0, k);
            el = (k >= 16);
            checks++; if (sdata !== e) begin fails++; $display("[TB] FAIL frame1_sdata bit %0d: got %b want %b", k, sdata, e); end
            checks++; if (lrck !== el) begin fails++; $display("[TB] FAIL frame1_lrck bit %0d: got %b want %b", k, lrck, el); end
            checks++; if (bck !== 1'b0) begin fails++; $display("[TB] FAIL frame1_bck_low bit %0d: got %b want 0", k, bck); end
            step(2);
            checks++; if (bck !== 1'b1) begin fails++; $display("[TB] FAIL frame1_bck_high bit %0d: got %b want 1", k, bck); end
            step(2);
        end
        checks++; if (fifo_level !== 3'd0) begin fails++; $display("[TB] FAIL frame2_level: got %0d want 0", fifo_level); end
        for (int k = 0; k < 32; k++) begin
            e = exp_bit(sb, 32, sa[0], k);
            el = (k >= 16);
            checks++; if (sdata !== e) begin fails++; $display("[TB] FAIL frame2_sdata bit %0d: got %b want %b", k, sdata, e); end
            checks++; if (lrck !== el) begin fails++; $display("[TB] FAIL frame2_lrck bit %0d: got %b want %b", k, lrck, el); end
            step(4);
        end
    endtask

    task automatic test_underrun();
        logic [127:0] sb;
        logic e;
        sb = 128'({B0, B1});
        apply_reset();
        prefill({A1, A0}, {B1, B0});
        step(128);
        checks++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL underrun_early: got %b want 0", underrun); end
        step(128);
        checks++; if (underrun !== 1'b1) begin fails++; $display("[TB] FAIL underrun_pulse: got %b want 1", underrun); end
        checks++; if (fifo_level !== 3'd0) begin fails++; $display("[TB] FAIL underrun_level: got %0d want 0", fifo_level); end
        e = exp_bit(128'd0, 32, sb[0], 0);
        checks++; if (sdata !== e) begin fails++; $display("[TB] FAIL underrun_bit0: got %b want %b", sdata, e); end
        step(1);
        checks++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL underrun_width: got %b want 0", underrun); end
        step(3);
        for (int k = 1; k < 32; k++) begin
            e = exp_bit(128'd0, 32, sb[0], k);
            checks++; if (sdata !== e) begin fails++; $display("[TB] FAIL underrun_sdata bit %0d: got %b want %b", k, sdata, e); end
            step(4);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        sample_valid = 1'b1;
        sample_in = {C1, C0};
        step(2);
        checks++; if (fifo_level !== 3'd2 || sample_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_two: got level %0d ready %b want 2/1", fifo_level, sample_ready); end
        step(2);
        checks++; if (fifo_level !== 3'd4) begin fails++; $display("[TB] FAIL bp_full_level: got %0d want 4", fifo_level); end
        checks++; if (sample_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_full_ready: got %b want 0", sample_ready); end
        step(1);
        checks++; if (fifo_level !== 3'd4) begin fails++; $display("[TB] FAIL bp_fifth_rejected: got %0d want 4", fifo_level); end
        step(2);
        checks++; if (fifo_level !== 3'd3 || sample_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_pop_when_full: got level %0d ready %b want 3/1", fifo_level, sample_ready); end
        step(1);
        checks++; if (fifo_level !== 3'd4 || sample_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_refill: got level %0d ready %b want 4/0", fifo_level, sample_ready); end
        sample_valid = 1'b0;
    endtask

    task automatic test_push_pop();
        apply_reset();
        sample_valid = 1'b1;
        sample_in = {A1, A0};
        step(1);
        sample_in = {B1, B0};
        step(1);
        sample_valid = 1'b0;
        step(4);
        sample_valid = 1'b1;
        sample_in = {C1, C0};
        step(1);
        sample_valid = 1'b0;
        checks++; if (fifo_level !== 3'd2) begin fails++; $display("[TB] FAIL push_pop_level: got %0d want 2", fifo_level); end
        step(1);
        checks++; if (fifo_level !== 3'd2) begin fails++; $display("[TB] FAIL push_pop_hold: got %0d want 2", fifo_level); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] sa;
        logic e, el;
        sa = 128'({A0, A1});
        apply_reset();
        prefill({A1, A0}, {B1, B0});
        step(98);
        reset = 1'b1;
        step(1);
        checks++; if (bck !== 1'b0 || lrck !== 1'b0 || sdata !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_pins: got bck %b lrck %b sdata %b want 0/0/0", bck, lrck, sdata); end
        checks++; if (fifo_level !== 3'd0 || sample_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_fifo: got level %0d ready %b want 0/1", fifo_level, sample_ready); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++; if (bck !== 1'b0 || sdata !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_quiet: got bck %b sdata %b want 0/0", bck, sdata); end
        end
        prefill({A1, A0}, {B1, B0});
        for (int k = 0; k < 32; k++) begin
            e = exp_bit(sa, 32, 1'b0, k);
            el = (k >= 16);
            checks++; if (sdata !== e) begin fails++; $display("[TB] FAIL rerun_sdata bit %0d: got %b want %b", k, sdata, e); end
            checks++; if (lrck !== el) begin fails++; $display("[TB] FAIL rerun_lrck bit %0d: got %b want %b", k, lrck, el); end
            step(4);
        end
    endtask

    task automatic test_tdm();
        logic [127:0] s4;
        logic e, el;
        s4 = {24'h123456, 8'h00, 24'hABCDEF, 8'h00, 24'h000001, 8'h00, 24'h800000, 8'h00};
        apply_reset();
        sample_in4 = {24'h800000, 24'h000001, 24'hABCDEF, 24'h123456};
        sample_valid4 = 1'b1;
        step(2);
        sample_valid4 = 1'b0;
        step(5);
        checks++; if (fifo_level4 !== 3'd1) begin fails++; $display("[TB] FAIL tdm_level: got %0d want 1", fifo_level4); end
        for (int k = 0; k < 128; k++) begin
            e = exp_bit(s4, 128, 1'b0, k);
            el = (k >= 64);
            checks++; if (sdata4 !== e) begin fails++; $display("[TB] FAIL tdm_sdata bit %0d: got %b want %b", k, sdata4, e); end
            checks++; if (lrck4 !== el) begin fails++; $display("[TB] FAIL tdm_lrck bit %0d: got %b want %b", k, lrck4, el); end
            step(4);
        end
        checks++; if (lrck4 !== 1'b0) begin fails++; $display("[TB] FAIL tdm_frame_wrap_lrck: got %b want 0", lrck4); end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_underrun();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_tdm();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
- Parametrised audio serialiser feeding the I2S_BCK/I2S_LRCK/I2S_DATA pins of the core top level (also mirrored to HDMI I2S).
- Generalises the fixed stereo 16-bit path to N channels, configurable sample and slot widths, and a frame FIFO.
- Adds a prefill start-up, underrun detection and a level report.
- Runs entirely in the core's system clock domain and derives the bit clock internally.

Parameters:
CHANNELS, 2, channels per frame; even, 2..8; >2 gives TDM.
SAMPLE_W, 16, bits per sample; 8..32.
SLOT_W, 16, bits per channel slot; must be >= SAMPLE_W; MSB-first, LSBs after the sample are zero-padded.
CLK_DIV, 4, clk cycles per bck period; even, >= 2.
FIFO_DEPTH, 4, frames buffered; power of 2, >= 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_in  in  CHANNELS*SAMPLE_W  one frame; channel 0 in the LSB slice
sample_valid  in  1  frame offered
sample_ready  out  1  FIFO can accept a frame
bck  out  1  bit clock
lrck  out  1  frame/word select
sdata  out  1  serial data
underrun  out  1  one-clk pulse when a frame start finds the FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  frames currently queued

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: bck=0, lrck=0, sdata=0, underrun=0, fifo_level=0, sample_ready=1. FIFO flushed, state=IDLE. Reset mid-frame aborts the frame immediately; no partial bits are emitted afterwards.
- Push handshake:
  - A frame is pushed when sample_valid && sample_ready.
  - sample_ready = (fifo_level != FIFO_DEPTH), derived from the registered level.
  - When full, a same-cycle pop does not raise ready until the next cycle.
  - Push and pop in the same cycle leave the level unchanged.
- Divider:
  - A counter counts 0..CLK_DIV-1 in RUN.
  - bck=1 for counts CLK_DIV/2..CLK_DIV-1.
  - The "fall tick" is the cycle the counter wraps to 0; all bck, lrck and sdata updates happen on fall ticks.
- Frame format:
  - FRAME_BITS = CHANNELS*SLOT_W; the bit index runs 0..FRAME_BITS-1 and wraps.
  - lrck=0 for bit indices 0..FRAME_BITS/2-1, lrck=1 for the rest (50% duty).
  - Standard I2S: the slot MSB is driven one bck period after the slot boundary, so the last bit of the frame carries the LSB-side pad of the last slot.
- State machine:
  - IDLE: bck/lrck/sdata held 0. Moves to RUN on the cycle after fifo_level >= FIFO_DEPTH/2 (prefill).
  - RUN: the divider runs and frames are emitted continuously. Remains in RUN until reset; there is no return to IDLE.
- Frame load, on the fall tick at bit index 0:
  - If the FIFO is not empty, pop one frame into the shift register.
  - If it is empty, load all zeros and pulse underrun for exactly one clk.
  - A push arriving in the same cycle as an empty-FIFO frame start is not used for that frame.
- First frame after entering RUN: bit index 0 begins at the first fall tick, which is CLK_DIV clks after entry.
- Width rules: channel c occupies sample_in[c*SAMPLE_W +: SAMPLE_W]. Samples are transmitted untouched, two's complement as given.

Optional Feature:
- Macro: I2S_TDM_TX_LJ_EN.
- Defined: left-justified format. The slot MSB is coincident with the slot boundary (no one-bit delay), and the last bit of the frame is the last pad/LSB bit of the final slot.
- Undefined: standard I2S one-bit delay as specified above.
- lrck timing is identical in both modes.

Decomposition:
- Package i2s_tdm_tx_pkg holds:
  - state typedef (IDLE, RUN)
  - function frame_bits(CHANNELS, SLOT_W)
  - function lvl_w(FIFO_DEPTH)
  - parameter-legality checks as elaboration-time assertions
- Sub-module sync_fifo (generic width/depth, single clock, sync reset, level output) stores frames. The serialiser, divider and FSM stay in i2s_tdm_tx.

Test Plan (defaults, i.e. CHANNELS=2, SAMPLE_W=16, SLOT_W=16, CLK_DIV=4, FIFO_DEPTH=4, unless stated):
1. Reset, then push frame {ch1=16'h8001, ch0=16'hA5C3} and one further frame -> RUN entered after level=2. In the first frame sdata carries bit sequence 0, then A5C3 MSB-first, then 8001 MSB-first shifted one bit; lrck toggles every 64 clk; bck period 4 clk.
2. Hold sample_valid=1 without the serialiser draining (stay in IDLE by pushing only 1 frame, then 3 more) -> after 4 pushes sample_ready=0 and fifo_level=4; a fifth offered frame is not accepted.
3. Prefill 2 frames then stop pushing -> after the 2nd frame drains, the next bit-0 fall tick yields underrun=1 for one clk, an all-zero frame on sdata, and fifo_level=0.
4. CHANNELS=4, SAMPLE_W=24, SLOT_W=32 with slots 0x123456/0xABCDEF/0x000001/0x800000 -> frame is 128 bck; lrck is low for slots 0-1 and high for slots 2-3; each sample is followed by 8 zero bits.
5. Build with I2S_TDM_TX_LJ_EN and the same stimulus as test 1 -> 16'hA5C3 MSB appears on the same fall tick that lrck goes 0.
6. Assert reset halfway through slot 1 -> the next clk shows bck=lrck=sdata=0, fifo_level=0, sample_ready=1; after re-prefill the output matches test 1 exactly.
